packet_source: RTL and testbench

Traffic generator BFM that injects numbered packets into a NoC fabric port; it sits directly upstream of the sink analyser, feeding the fabric input port of node NODE. Each packet carries return, source, destination, VC, generator ID and a sequence counter, packed so the downstream sink decodes it unchanged. It issues a fixed number of packets under valid/ready flow control with a programmable inter-packet gap, then raises done.

---
 rtl/packet_source.sv | 171 +++++++++++++++++
 tb/tb_packet_source.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/packet_source.sv
// packet_source: numbered-packet traffic generator for one NoC fabric input port.
//
// The block issues packets with sequence numbers 1..NUM_TESTS under valid/ready
// flow control. After each accepted packet it can insert GAP idle cycles. When
// the last packet is accepted it raises done.
//
// Each packet is laid out MSB first as:
//   {return=NODE, return_vc=VC, src=NODE, dst, vc=VC, id=ID, seq}
// The downstream sink decodes this layout unchanged.
//
// Ports:
//   clk        clock; all state is updated on its rising edge
//   rst        synchronous, active-high reset
//   enable     start or resume injection; sampled in IDLE and at the end of a gap
//   data_out   packet offered to the fabric
//   valid_out  data_out is valid
//   ready_in   downstream accepts data_out on this edge when valid_out is high
//   sent_count number of packets accepted so far (DATA_W bits)
//   done       all NUM_TESTS packets have been accepted
//
// Optional feature macro: PACKET_SOURCE_TRACE_EN.
//   When it is defined, every transfer is also reported with $display.
module packet_source #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned N             = 16,
  parameter int unsigned NUM_VC        = 2,
  parameter int unsigned N_ADDR_WIDTH  = $clog2(N),
  parameter int unsigned VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter logic [7:0]  ID            = 8'd0,
  parameter int unsigned NODE          = 0,
  parameter int unsigned DST           = 15,
  parameter bit          ROTATE        = 1'b0,
  parameter int unsigned VC            = 0,
  parameter int unsigned GAP           = 0,
  parameter int unsigned NUM_TESTS     = 1000
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       enable,
  output logic [WIDTH-1:0]                                           data_out,
  output logic                                                       valid_out,
  input  logic                                                       ready_in,
  output logic [WIDTH-3*N_ADDR_WIDTH-2*VC_ADDR_WIDTH-8-1:0]          sent_count,
  output logic                                                       done
);

  localparam int unsigned DATA_W = WIDTH - 3*N_ADDR_WIDTH - 2*VC_ADDR_WIDTH - 8;
  localparam int unsigned GAP_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [N_ADDR_WIDTH-1:0]  NODE_F = N_ADDR_WIDTH'(NODE);
  localparam logic [VC_ADDR_WIDTH-1:0] VC_F   = VC_ADDR_WIDTH'(VC);
  localparam logic [N_ADDR_WIDTH-1:0]  DST_F  = N_ADDR_WIDTH'(DST);
  localparam logic [DATA_W-1:0]        LAST_F = DATA_W'(NUM_TESTS);
  localparam logic [GAP_W-1:0]         GAP_F  = GAP_W'(GAP);

  if ((NUM_TESTS + 1) >= (1 << DATA_W)) begin : g_err_count
    $error("packet_source: NUM_TESTS does not fit in the sequence field");
  end
  if (DST >= N) begin : g_err_dst
    $error("packet_source: DST is not a valid node index");
  end
  if (DST == NODE && !ROTATE) begin : g_err_self
    $error("packet_source: DST equals NODE with rotation disabled");
  end

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e                 state;
  logic [DATA_W-1:0]      seq;
  logic [N_ADDR_WIDTH-1:0] dst;
  logic [GAP_W-1:0]       gap_cnt;

  function automatic logic [WIDTH-1:0] pack(input logic [DATA_W-1:0]       s,
                                            input logic [N_ADDR_WIDTH-1:0] d);
    return {NODE_F, VC_F, NODE_F, d, VC_F, ID, s};
  endfunction

  // With rotation the destination walks through every node except our own.
  function automatic logic [N_ADDR_WIDTH-1:0] next_dst(input logic [N_ADDR_WIDTH-1:0] cur);
    int unsigned nxt;
    if (!ROTATE) return cur;
    nxt = (32'(cur) + 32'd1) % N;
    if (nxt == NODE) nxt = (nxt + 32'd1) % N;
    return N_ADDR_WIDTH'(nxt);
  endfunction

  logic [DATA_W-1:0]       seq_nxt;
  logic [N_ADDR_WIDTH-1:0] dst_nxt;
  always_comb begin
    seq_nxt = seq + 1'b1;
    dst_nxt = next_dst(dst);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      valid_out  <= 1'b0;
      data_out   <= '0;
      sent_count <= '0;
      done       <= 1'b0;
      seq        <= DATA_W'(1);
      dst        <= DST_F;
      gap_cnt    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (enable) begin
            data_out  <= pack(seq, dst);
            valid_out <= 1'b1;
            state     <= StSend;
          end
        end
        StSend: begin
          if (ready_in) begin
            sent_count <= sent_count + 1'b1;
            if (seq == LAST_F) begin
              valid_out <= 1'b0;
              done      <= 1'b1;
              state     <= StDone;
            end else begin
              seq <= seq_nxt;
              dst <= dst_nxt;
              if (GAP == 0 && enable) begin
                // Back-to-back: the next packet replaces the accepted one.
                data_out <= pack(seq_nxt, dst_nxt);
              end else begin
                valid_out <= 1'b0;
                if (GAP > 0) begin
                  gap_cnt <= GAP_F;
                  state   <= StGap;
                end else begin
                  state <= StIdle;
                end
              end
            end
          end
        end
        StGap: begin
          // The counter reaches zero on the last idle cycle, so exactly GAP
          // cycles pass with valid_out low.
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) begin
            if (enable) begin
              data_out  <= pack(seq, dst);
              valid_out <= 1'b1;
              state     <= StSend;
            end else begin
              state <= StIdle;
            end
          end
        end
        StDone: begin
          valid_out <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef PACKET_SOURCE_TRACE_EN
  always @(posedge clk) begin
    if (!rst && state == StSend && ready_in) begin
      $display("SOURCE=%0d; time=%0t; from=%0d; to=%0d; data=%0d;",
               ID, $time, NODE, dst, seq);
    end
  end
`else
  // Trace disabled.
`endif

endmodule

// File: tb/tb_packet_source.sv
module tb_packet_source;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Default configuration.
  logic        en_a, rdy_a, val_a, done_a;
  logic [31:0] dat_a;
  logic [9:0]  cnt_a;
  // GAP=3 with distinct field values.
  logic        en_g, rdy_g, val_g, done_g;
  logic [31:0] dat_g;
  logic [9:0]  cnt_g;
  // Rotating destination on a 4-node fabric.
  logic        en_r, rdy_r, val_r, done_r;
  logic [31:0] dat_r;
  logic [15:0] cnt_r;

  packet_source u_dut (
    .clk(clk), .rst(rst), .enable(en_a), .data_out(dat_a), .valid_out(val_a),
    .ready_in(rdy_a), .sent_count(cnt_a), .done(done_a)
  );

  packet_source #(.ID(8'hA5), .NODE(3), .DST(9), .VC(1), .GAP(3), .NUM_TESTS(20)) u_gap (
    .clk(clk), .rst(rst), .enable(en_g), .data_out(dat_g), .valid_out(val_g),
    .ready_in(rdy_g), .sent_count(cnt_g), .done(done_g)
  );

  packet_source #(.N(4), .NODE(2), .DST(0), .ROTATE(1'b1), .NUM_TESTS(7)) u_rot (
    .clk(clk), .rst(rst), .enable(en_r), .data_out(dat_r), .valid_out(val_r),
    .ready_in(rdy_r), .sent_count(cnt_r), .done(done_r)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // 32-bit packet with N=16, NUM_VC=2: {ret4, rvc1, src4, dst4, vc1, id8, seq10}.
  function automatic logic [31:0] pkt_a(input logic [3:0] node, input logic vc,
                                        input logic [3:0] d, input logic [7:0] id,
                                        input logic [9:0] s);
    return {node, vc, node, d, vc, id, s};
  endfunction

  // 32-bit packet with N=4, NODE=2, VC=0, ID=0: {ret2, rvc1, src2, dst2, vc1, id8, seq16}.
  function automatic logic [31:0] pkt_r(input logic [1:0] d, input logic [15:0] s);
    return {2'd2, 1'b0, 2'd2, d, 1'b0, 8'd0, s};
  endfunction

  logic [1:0] rot_dst [7];

  initial begin
    rot_dst = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
    rst = 1'b1;
    en_a = 1'b0; rdy_a = 1'b0;
    en_g = 1'b0; rdy_g = 1'b0;
    en_r = 1'b0; rdy_r = 1'b0;
    step(); step();

    // Reset state.
    check_eq("rst_valid", 64'(val_a), 64'd0);
    check_eq("rst_data", 64'(dat_a), 64'd0);
    check_eq("rst_count", 64'(cnt_a), 64'd0);
    check_eq("rst_done", 64'(done_a), 64'd0);

    // Back-pressure: hold seq=3 for 5 cycles of ready_in low.
    rst = 1'b0; en_a = 1'b1; rdy_a = 1'b1;
    step();
    check_eq("stall_p1", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'd1)});
    step();
    check_eq("stall_p2", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'd2)});
    step();
    check_eq("stall_p3", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'd3)});
    rdy_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("stall_hold", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'd3)});
      check_eq("stall_cnt", 64'(cnt_a), 64'd2);
    end
    rdy_a = 1'b1;
    step();
    check_eq("stall_p4", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'd4)});
    check_eq("stall_cnt4", 64'(cnt_a), 64'd3);

    // Full back-to-back run of 1000 packets.
    rst = 1'b1;
    step();
    check_eq("rerst_valid", 64'(val_a), 64'd0);
    rst = 1'b0;
    step();
    for (int i = 1; i <= 1000; i++) begin
      check_eq("stream", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'(i))});
      step();
    end
    check_eq("end_done", 64'(done_a), 64'd1);
    check_eq("end_count", 64'(cnt_a), 64'd1000);
    check_eq("end_valid", 64'(val_a), 64'd0);
    step(); step(); step();
    check_eq("hold_done", 64'(done_a), 64'd1);
    check_eq("hold_count", 64'(cnt_a), 64'd1000);
    check_eq("hold_valid", 64'(val_a), 64'd0);

    // Reset while seq=50 is offered.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 1; i < 50; i++) step();
    check_eq("mid_p50", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'd50)});
    rst = 1'b1;
    step();
    check_eq("mid_valid", 64'(val_a), 64'd0);
    check_eq("mid_count", 64'(cnt_a), 64'd0);
    check_eq("mid_done", 64'(done_a), 64'd0);
    rst = 1'b0;
    step();
    check_eq("mid_p1", {31'd0, val_a, dat_a}, {31'd0, 1'b1, pkt_a(0, 0, 15, 0, 10'd1)});
    en_a = 1'b0;

    // GAP=3: transfers four cycles apart; enable dropped in the gap after seq 7.
    en_g = 1'b1; rdy_g = 1'b1;
    step();
    for (int k = 1; k <= 7; k++) begin
      check_eq("gap_pkt", {31'd0, val_g, dat_g},
               {31'd0, 1'b1, pkt_a(3, 1, 9, 8'hA5, 10'(k))});
      step();
      check_eq("gap_cnt", 64'(cnt_g), 64'(k));
      for (int j = 0; j < 3; j++) begin
        check_eq("gap_low", 64'(val_g), 64'd0);
        if (k == 7 && j == 0) en_g = 1'b0;
        step();
      end
    end
    for (int k = 0; k < 6; k++) begin
      check_eq("gap_off", 64'(val_g), 64'd0);
      step();
    end
    check_eq("gap_off_cnt", 64'(cnt_g), 64'd7);
    en_g = 1'b1;
    step();
    check_eq("gap_resume", {31'd0, val_g, dat_g},
             {31'd0, 1'b1, pkt_a(3, 1, 9, 8'hA5, 10'd8)});
    check_eq("gap_done", 64'(done_g), 64'd0);
    en_g = 1'b0;

    // Rotating destination skips our own node.
    en_r = 1'b1; rdy_r = 1'b1;
    step();
    for (int i = 1; i <= 7; i++) begin
      check_eq("rot_pkt", {31'd0, val_r, dat_r}, {31'd0, 1'b1, pkt_r(rot_dst[i-1], 16'(i))});
      step();
    end
    check_eq("rot_done", 64'(done_r), 64'd1);
    check_eq("rot_count", 64'(cnt_r), 64'd7);
    check_eq("rot_valid", 64'(val_r), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
